// File: rtl/ibex_tb_mem_pkg.sv
// Shared types for the testrig memory arbiter: bus owner, request bundle,
// default RAM window base.
package ibex_tb_mem_pkg;

    typedef enum logic {
        ARB_INSTR,
        ARB_DATA
    } arb_owner_e;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h0010_0000;
    localparam logic [3:0]  BE_WORD           = 4'hF;

endpackage

// File: rtl/ibex_tb_mem_arb_sel.sv
// Two-way request selector; fixed data priority by default, round-robin
// on contention when IBEX_TB_MEM_ARB_RR_EN is defined.
module ibex_tb_mem_arb_sel
    import ibex_tb_mem_pkg::*;
(
    input  logic       instr_req_i,
    input  logic       data_req_i,
    input  arb_owner_e rr_last_i,
    output logic [1:0] gnt_o,
    output arb_owner_e owner_o
);

    arb_owner_e contended;
    logic       any_req;

`ifdef IBEX_TB_MEM_ARB_RR_EN
    assign contended = (rr_last_i == ARB_DATA) ? ARB_INSTR : ARB_DATA;
`else
    logic unused_rr;
    assign unused_rr = rr_last_i;
    assign contended = ARB_DATA;
`endif

    assign any_req = instr_req_i | data_req_i;

    always_comb begin
        owner_o = ARB_DATA;
        unique case (1'b1)
            instr_req_i && data_req_i:  owner_o = contended;
            data_req_i && !instr_req_i: owner_o = ARB_DATA;
            instr_req_i && !data_req_i: owner_o = ARB_INSTR;
            default:                    owner_o = ARB_DATA;
        endcase
    end

    assign gnt_o[0] = any_req & (owner_o == ARB_INSTR);
    assign gnt_o[1] = any_req & (owner_o == ARB_DATA);

endmodule

// File: rtl/ibex_tb_mem_arbiter.sv
// Shares one single-port RAM between Ibex instr and data buses.
// Option: IBEX_TB_MEM_ARB_RR_EN enables round-robin arbitration.
module ibex_tb_mem_arbiter
    import ibex_tb_mem_pkg::*;
#(
    parameter int unsigned Depth    = 16384,
    parameter logic [31:0] BaseAddr = BASE_ADDR_DEFAULT,
    parameter int unsigned AddrW    = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_ni,

    input  logic             instr_req_i,
    input  logic [31:0]      instr_addr_i,
    output logic             instr_gnt_o,
    output logic             instr_rvalid_o,
    output logic [31:0]      instr_rdata_o,
    output logic             instr_err_o,

    input  logic             data_req_i,
    input  logic             data_we_i,
    input  logic [3:0]       data_be_i,
    input  logic [31:0]      data_addr_i,
    input  logic [31:0]      data_wdata_i,
    output logic             data_gnt_o,
    output logic             data_rvalid_o,
    output logic [31:0]      data_rdata_o,
    output logic             data_err_o,

    output logic             ram_req_o,
    output logic             ram_we_o,
    output logic [3:0]       ram_be_o,
    output logic [AddrW-1:0] ram_addr_o,
    output logic [31:0]      ram_wdata_o,
    input  logic [31:0]      ram_rdata_i
);

    // 33 bits so a 4 GiB window still compares correctly
    localparam logic [32:0] WinBytes = 33'(Depth) << 2;

    mem_req_t   instr_req_s;
    mem_req_t   data_req_s;
    mem_req_t   req_sel;
    logic [1:0] sel_gnt;
    arb_owner_e sel_owner;
    arb_owner_e rr_last;
    logic       any_gnt;
    logic [31:0] off;
    logic       hit;

    logic       resp_valid_q;
    arb_owner_e resp_owner_q;
    logic       resp_err_q;
    logic       rsp_instr;
    logic       rsp_data;

    always_comb begin
        instr_req_s      = '0;
        instr_req_s.be   = BE_WORD;
        instr_req_s.addr = instr_addr_i;
    end

    always_comb begin
        data_req_s       = '0;
        data_req_s.we    = data_we_i;
        data_req_s.be    = data_be_i;
        data_req_s.addr  = data_addr_i;
        data_req_s.wdata = data_wdata_i;
    end

`ifdef IBEX_TB_MEM_ARB_RR_EN
    arb_owner_e rr_last_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_last_q <= ARB_DATA;
        end else if (any_gnt) begin
            rr_last_q <= sel_owner;
        end
    end

    assign rr_last = rr_last_q;
`else
    assign rr_last = ARB_DATA;
`endif

    ibex_tb_mem_arb_sel u_sel (
        .instr_req_i (instr_req_i),
        .data_req_i  (data_req_i),
        .rr_last_i   (rr_last),
        .gnt_o       (sel_gnt),
        .owner_o     (sel_owner)
    );

    assign instr_gnt_o = rst_ni & sel_gnt[0];
    assign data_gnt_o  = rst_ni & sel_gnt[1];
    assign any_gnt     = instr_gnt_o | data_gnt_o;

    assign req_sel = (sel_owner == ARB_DATA) ? data_req_s : instr_req_s;

    // Addresses below the base wrap to huge offsets and miss
    assign off = req_sel.addr - BaseAddr;
    assign hit = {1'b0, off} < WinBytes;

    assign ram_req_o   = any_gnt & hit;
    assign ram_we_o    = ram_req_o & req_sel.we;
    assign ram_be_o    = ram_req_o ? req_sel.be : '0;
    assign ram_addr_o  = ram_req_o ? off[AddrW+1:2] : '0;
    assign ram_wdata_o = ram_req_o ? req_sel.wdata : '0;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            resp_valid_q <= 1'b0;
            resp_owner_q <= ARB_INSTR;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= any_gnt;
            if (any_gnt) begin
                resp_owner_q <= sel_owner;
                resp_err_q   <= ~hit;
            end
        end
    end

    assign rsp_instr = resp_valid_q & (resp_owner_q == ARB_INSTR);
    assign rsp_data  = resp_valid_q & (resp_owner_q == ARB_DATA);

    assign instr_rvalid_o = rsp_instr;
    assign instr_err_o    = rsp_instr & resp_err_q;
    assign instr_rdata_o  = (rsp_instr && !resp_err_q) ? ram_rdata_i : '0;

    assign data_rvalid_o  = rsp_data;
    assign data_err_o     = rsp_data & resp_err_q;
    assign data_rdata_o   = (rsp_data && !resp_err_q) ? ram_rdata_i : '0;

`ifdef INC_ASSERT
    a_one_gnt: assert property (@(posedge clk_i)
        !(instr_gnt_o && data_gnt_o));

    a_instr_rsp: assert property (@(posedge clk_i) disable iff (!rst_ni)
        instr_gnt_o |=> instr_rvalid_o && !data_rvalid_o);

    a_data_rsp: assert property (@(posedge clk_i) disable iff (!rst_ni)
        data_gnt_o |=> data_rvalid_o && !instr_rvalid_o);

    a_ram_gnt: assert property (@(posedge clk_i)
        ram_req_o |-> any_gnt);
`endif

endmodule

// File: tb/tb_ibex_tb_mem_arbiter.sv
// Randomized bench for ibex_tb_mem_arbiter with a transaction-level model
// and directed literal checks.
module tb_ibex_tb_mem_arbiter;

    localparam int unsigned DEPTH = 16384;
    localparam int unsigned AW    = 14;
    localparam logic [31:0] BASE  = 32'h0010_0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          instr_req = 1'b0;
    logic [31:0]   instr_addr = '0;
    logic          instr_gnt;
    logic          instr_rvalid;
    logic [31:0]   instr_rdata;
    logic          instr_err;
    logic          data_req = 1'b0;
    logic          data_we = 1'b0;
    logic [3:0]    data_be = '0;
    logic [31:0]   data_addr = '0;
    logic [31:0]   data_wdata = '0;
    logic          data_gnt;
    logic          data_rvalid;
    logic [31:0]   data_rdata;
    logic          data_err;
    logic          ram_req;
    logic          ram_we;
    logic [3:0]    ram_be;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ibex_tb_mem_arbiter dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .instr_req_i    (instr_req),
        .instr_addr_i   (instr_addr),
        .instr_gnt_o    (instr_gnt),
        .instr_rvalid_o (instr_rvalid),
        .instr_rdata_o  (instr_rdata),
        .instr_err_o    (instr_err),
        .data_req_i     (data_req),
        .data_we_i      (data_we),
        .data_be_i      (data_be),
        .data_addr_i    (data_addr),
        .data_wdata_i   (data_wdata),
        .data_gnt_o     (data_gnt),
        .data_rvalid_o  (data_rvalid),
        .data_rdata_o   (data_rdata),
        .data_err_o     (data_err),
        .ram_req_o      (ram_req),
        .ram_we_o       (ram_we),
        .ram_be_o       (ram_be),
        .ram_addr_o     (ram_addr),
        .ram_wdata_o    (ram_wdata),
        .ram_rdata_i    (ram_rdata)
    );

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // RAM environment: 1-cycle read latency
    logic [31:0] ram  [DEPTH];
    logic [31:0] gold [DEPTH];

    always @(posedge clk) begin
        if (ram_req) begin
            if (ram_we) ram[ram_addr] <= merge(ram[ram_addr], ram_wdata, ram_be);
            ram_rdata <= ram[ram_addr];
        end
    end

    // Transaction-level model
    bit          m_last_data = 1'b1;
    bit          p_v = 1'b0;
    bit          p_data = 1'b0;
    bit          p_err = 1'b0;
    bit          p_chk = 1'b0;
    logic [31:0] p_rdata = '0;
    bit          e_ig, e_dg, e_hit, e_rq;
    logic [31:0] e_a, e_off;
    logic [31:0] e_be, e_wd, e_we;
    int unsigned e_idx;

    always @(negedge clk) begin
        e_ig = 1'b0;
        e_dg = 1'b0;
        if (rst_n) begin
            if (instr_req && data_req) begin
`ifdef IBEX_TB_MEM_ARB_RR_EN
                if (m_last_data) e_ig = 1'b1;
                else e_dg = 1'b1;
`else
                e_dg = 1'b1;
`endif
            end else begin
                e_ig = instr_req;
                e_dg = data_req;
            end
        end
        e_a   = e_dg ? data_addr : instr_addr;
        e_off = e_a - BASE;
        e_hit = e_off < DEPTH * 4;
        e_rq  = (e_ig || e_dg) && e_hit;
        e_idx = e_off[AW+1:2];
        e_we  = (e_rq && e_dg) ? 32'(data_we) : 32'd0;
        e_be  = !e_rq ? 32'd0 : e_dg ? 32'(data_be) : 32'hF;
        e_wd  = (e_rq && e_dg) ? data_wdata : 32'd0;

        chk("instr_gnt", 32'(instr_gnt), 32'(e_ig));
        chk("data_gnt", 32'(data_gnt), 32'(e_dg));
        chk("ram_req", 32'(ram_req), 32'(e_rq));
        chk("ram_we", 32'(ram_we), e_we);
        chk("ram_be", 32'(ram_be), e_be);
        chk("ram_addr", 32'(ram_addr), e_rq ? e_idx : 32'd0);
        chk("ram_wdata", ram_wdata, e_wd);
        chk("instr_rvalid", 32'(instr_rvalid), 32'(p_v && !p_data));
        chk("data_rvalid", 32'(data_rvalid), 32'(p_v && p_data));
        if (p_v) begin
            chk("instr_err", 32'(instr_err), 32'(p_err && !p_data));
            chk("data_err", 32'(data_err), 32'(p_err && p_data));
            if (p_data) chk("instr_rdata_idle", instr_rdata, 32'd0);
            else        chk("data_rdata_idle", data_rdata, 32'd0);
            if (p_chk) begin
                if (p_data) chk("data_rdata", data_rdata, p_rdata);
                else        chk("instr_rdata", instr_rdata, p_rdata);
            end
        end

        if (e_ig || e_dg) begin
            p_v     = 1'b1;
            p_data  = e_dg;
            p_err   = !e_hit;
            p_chk   = !(e_dg && data_we && e_hit);
            p_rdata = e_hit ? gold[e_idx] : 32'd0;
            if (e_dg && data_we && e_hit)
                gold[e_idx] = merge(gold[e_idx], data_wdata, data_be);
            m_last_data = e_dg;
        end else begin
            p_v = 1'b0;
        end
        if (!rst_n) m_last_data = 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        instr_req  = 1'b0;
        instr_addr = '0;
        data_req   = 1'b0;
        data_we    = 1'b0;
        data_be    = '0;
        data_addr  = '0;
        data_wdata = '0;
    endtask

    task automatic dreq(input logic we, input logic [3:0] be,
                        input logic [31:0] a, input logic [31:0] wd);
        data_req   = 1'b1;
        data_we    = we;
        data_be    = be;
        data_addr  = a;
        data_wdata = wd;
    endtask

    function automatic logic [31:0] rand_addr();
        unsigned_case: case ($urandom % 8)
            0: return BASE + DEPTH * 4 + ($urandom % 64) * 4;
            1: return BASE - 4 * (1 + ($urandom % 16));
            2: return $urandom;
            default: return BASE + ($urandom % 64) * 4;
        endcase
    endfunction

    int n_cont;
    int cnt_i;
    int cnt_d;
    bit exp_d;
    bit prev_d;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]  = i * 32'h9E3779B9;
            gold[i] = i * 32'h9E3779B9;
        end
        ram[2]  = 32'hDEADBEEF;
        gold[2] = 32'hDEADBEEF;

        // Reset with both requesting: grants forced low
        idle();
        rst_n = 1'b0;
        instr_req = 1'b1;
        data_req  = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("rst_instr_gnt", 32'(instr_gnt), 32'd0);
        chk("rst_data_gnt", 32'(data_gnt), 32'd0);
        chk("rst_ram_req", 32'(ram_req), 32'd0);
        chk("rst_rvalid", 32'({instr_rvalid, data_rvalid}), 32'd0);
        chk("rst_err", 32'({instr_err, data_err}), 32'd0);
        chk("rst_rdata", instr_rdata | data_rdata, 32'd0);
        step();

        // Contention from reset
`ifdef IBEX_TB_MEM_ARB_RR_EN
        n_cont = 4;
`else
        n_cont = 3;
`endif
        rst_n = 1'b1;
        cnt_i = 0;
        cnt_d = 0;
        prev_d = 1'b0;
        for (int i = 0; i < n_cont; i++) begin
            instr_req  = 1'b1;
            instr_addr = BASE + 32'(i) * 16;
            dreq(1'b0, 4'hF, BASE + 32'h100 + 32'(i) * 4, '0);
            @(negedge clk);
`ifdef IBEX_TB_MEM_ARB_RR_EN
            exp_d = (i % 2) == 1;
`else
            exp_d = 1'b1;
`endif
            chk("cont_data_gnt", 32'(data_gnt), 32'(exp_d));
            chk("cont_instr_gnt", 32'(instr_gnt), 32'(!exp_d));
            if (i > 0) chk("cont_owner", 32'(data_rvalid), 32'(prev_d));
            cnt_i += int'(instr_rvalid);
            cnt_d += int'(data_rvalid);
            prev_d = exp_d;
            step();
        end
        idle();
        @(negedge clk);
        chk("cont_owner_last", 32'(data_rvalid), 32'(prev_d));
        cnt_i += int'(instr_rvalid);
        cnt_d += int'(data_rvalid);
`ifdef IBEX_TB_MEM_ARB_RR_EN
        chk("cont_instr_pulses", 32'(cnt_i), 32'd2);
        chk("cont_data_pulses", 32'(cnt_d), 32'd2);
`else
        chk("cont_instr_pulses", 32'(cnt_i), 32'd0);
        chk("cont_data_pulses", 32'(cnt_d), 32'd3);
`endif
        step();

        // Instruction read of word 2
        instr_req  = 1'b1;
        instr_addr = BASE + 8;
        @(negedge clk);
        chk("ird_gnt", 32'(instr_gnt), 32'd1);
        chk("ird_ram_addr", 32'(ram_addr), 32'd2);
        chk("ird_ram_we", 32'(ram_we), 32'd0);
        step();
        idle();
        @(negedge clk);
        chk("ird_rvalid", 32'(instr_rvalid), 32'd1);
        chk("ird_rdata", instr_rdata, 32'hDEADBEEF);
        chk("ird_err", 32'(instr_err), 32'd0);
        step();

        // Partial write then read back word 1
        dreq(1'b1, 4'b0011, BASE + 4, 32'h1234ABCD);
        step();
        dreq(1'b0, 4'hF, BASE + 4, '0);
        @(negedge clk);
        chk("wr_rvalid", 32'(data_rvalid), 32'd1);
        chk("wr_err", 32'(data_err), 32'd0);
        step();
        idle();
        @(negedge clk);
        chk("rd_rdata", data_rdata, 32'h9E37ABCD);
        step();

        // Misses above and below the window
        dreq(1'b0, 4'hF, BASE + DEPTH * 4, '0);
        @(negedge clk);
        chk("dmiss_gnt", 32'(data_gnt), 32'd1);
        chk("dmiss_ram_req", 32'(ram_req), 32'd0);
        step();
        idle();
        instr_req  = 1'b1;
        instr_addr = BASE - 4;
        @(negedge clk);
        chk("dmiss_rsp", 32'({data_rvalid, data_err}), 32'b11);
        chk("dmiss_rdata", data_rdata, 32'd0);
        chk("imiss_gnt", 32'(instr_gnt), 32'd1);
        chk("imiss_ram_req", 32'(ram_req), 32'd0);
        step();
        idle();
        @(negedge clk);
        chk("imiss_rsp", 32'({instr_rvalid, instr_err}), 32'b11);
        chk("imiss_rdata", instr_rdata, 32'd0);
        step();

        // Reset while a data request is pending
        dreq(1'b0, 4'hF, BASE + 12, '0);
        step();
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_gnt", 32'(data_gnt), 32'd0);
        chk("mrst_ram_req", 32'(ram_req), 32'd0);
        step();
        @(negedge clk);
        chk("mrst_no_rvalid", 32'(data_rvalid), 32'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_resume_gnt", 32'(data_gnt), 32'd1);
        step();

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            rst_n      = ($urandom % 200) != 0;
            instr_req  = ($urandom % 3) != 0;
            instr_addr = rand_addr();
            data_req   = ($urandom % 2) != 0;
            data_we    = ($urandom % 2) != 0;
            data_be    = 4'($urandom);
            data_addr  = rand_addr();
            data_wdata = $urandom;
            step();
        end
        idle();
        rst_n = 1'b1;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
